// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, latency counter width and alignment check for dmem_hs
package dmem_pkg;
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} st_t;
  localparam int LAT_W = 3;
  function automatic logic misaligned(input logic [31:0] addr, input logic [31:0] bytes);
    return |(addr & (bytes - 32'd1));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: WORDS x DATA_W RAM, per-lane write enables, registered read (old data on same-edge write)
//  i_clk clock | i_we lane write enables | i_addr word index | i_wdata write word
//  i_re read capture enable | o_rdata captured word, held until the next i_re
module dmem_array #(
  parameter int WORDS  = 256,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic [DATA_W/8-1:0]      i_we,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < DATA_W/8; b++)
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: byte-masked data memory with valid/ready request/response, post-reset clear sweep
//  i_clk clock | i_reset async active-low reset
//  i_req_valid/o_req_ready request handshake | i_req_addr byte address | i_req_wren write
//  i_req_bmask write lanes | i_req_wdata write data
//  o_rsp_valid/i_rsp_ready response handshake | o_rsp_rdata word at accept | o_rsp_err misaligned
//  o_busy clear sweep running
module dmem_hs import dmem_pkg::*; #(
  parameter int DEPTH   = 1024,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [$clog2(DEPTH)-1:0] i_req_addr,
  input  logic                     i_req_wren,
  input  logic [DATA_W/8-1:0]      i_req_bmask,
  input  logic [DATA_W-1:0]        i_req_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_W-1:0]        o_rsp_rdata,
  output logic                     o_rsp_err,
  output logic                     o_busy
);
  localparam int BYTES = DATA_W/8;
  localparam int AW    = $clog2(DEPTH);
  localparam int BW    = $clog2(BYTES);
  localparam int WORDS = DEPTH/BYTES;
  localparam int WAW   = AW - BW;
  st_t              r_state, w_nstate;
  logic [WAW-1:0]   r_ptr;
  logic [LAT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_acc, w_mis;
  logic [BYTES-1:0] w_we;
  logic [WAW-1:0]   w_addr;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  assign w_mis = misaligned(32'(i_req_addr), 32'(BYTES));
  assign w_acc = (r_state == ST_IDLE) && i_req_valid;
  // The sweep owns the write port during CLEAR; otherwise an accepted aligned write does.
  always_comb begin
    w_nstate = r_state;
    w_we     = '0;
    w_addr   = i_req_addr[AW-1:BW];
    w_wdata  = i_req_wdata;
    case (r_state)
      ST_CLEAR: begin
        w_we     = '1;
        w_addr   = r_ptr;
        w_wdata  = '0;
        w_nstate = &r_ptr ? ST_IDLE : ST_CLEAR;
      end
      ST_IDLE: if (i_req_valid) begin
        w_we     = (i_req_wren && !w_mis) ? i_req_bmask : '0;
        w_nstate = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: w_nstate = (r_cnt == '0) ? ST_RESP : ST_WAIT;
      ST_RESP: w_nstate = i_rsp_ready ? ST_IDLE : ST_RESP;
      default: w_nstate = ST_CLEAR;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (r_state == ST_CLEAR) r_ptr <= r_ptr + 1'b1;
      if (w_acc) begin
        r_cnt <= LAT_W'(LATENCY - 2);
        r_err <= w_mis;
      end else if (r_state == ST_WAIT) r_cnt <= r_cnt - 1'b1;
    end
  end
  dmem_array #(.WORDS(WORDS), .DATA_W(DATA_W)) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_re    (w_acc),
    .o_rdata (w_rdata)
  );
  // Outputs derive from the async-reset state, so they drop the moment reset asserts.
  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_busy      = (r_state == ST_CLEAR);
  assign o_rsp_err   = o_rsp_valid && r_err;
  assign o_rsp_rdata = (o_rsp_valid && !r_err) ? w_rdata : '0;
endmodule
